// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-BRAM port between the CPU MEM stage
// and an external master (UART loader / debug DMA). The CPU normally wins;
// a waiting external request is forced through after MAX_WAIT cycles, and a
// locked external sequence keeps the port (and the CPU stalled) until it ends.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_W/8-1:0]   cpu_be,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_din,
    output logic                  cpu_stall,
    output logic [DATA_W-1:0]     cpu_dout,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [DATA_W/8-1:0]   ext_be,
    input  logic [ADDR_W-1:0]     ext_addr,
    input  logic [DATA_W-1:0]     ext_din,
    input  logic                  ext_lock,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_W-1:0]     ext_rdata,
    output logic                  mem_wea,
    output logic [DATA_W/8-1:0]   mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    typedef enum logic {
        CPU_OWN,
        EXT_OWN
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        waitCnt_q, waitCnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              cpuGo;

    // Decide who owns the port this cycle; everything is held off while in reset.
    always_comb begin
        ext_gnt   = 1'b0;
        cpu_stall = 1'b0;
        if (Rst) begin
            unique case (state_q)
                CPU_OWN: begin
                    ext_gnt   = ext_req & (~cpu_req | (waitCnt_q == MaxWait));
                    cpu_stall = cpu_req & ext_gnt;
                end
                EXT_OWN: begin
                    ext_gnt   = ext_req;
                    cpu_stall = 1'b1;
                end
            endcase
        end
    end

    // A stalled CPU access is not performed, so it must not reach the BRAM write strobe
    // (this matters when a locked owner is idle and the mux falls back to the CPU side).
    assign cpuGo = Rst & cpu_req & ~cpu_stall;

    // Steer the selected requester onto the BRAM port; idle cycles never write.
    always_comb begin
        if (ext_gnt) begin
            mem_addr = ext_addr;
            mem_en   = ext_be;
            mem_din  = ext_din;
            mem_wea  = ext_we & ext_req;
        end else begin
            mem_addr = cpu_addr;
            mem_en   = cpu_be;
            mem_din  = cpu_din;
            mem_wea  = cpu_we & cpuGo;
        end
    end

    // Next-state logic: ownership transfer, starvation counter and read return.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CPU_OWN: if (ext_gnt & ext_lock)  state_d = EXT_OWN;
            EXT_OWN: if (ext_gnt & ~ext_lock) state_d = CPU_OWN;
        endcase

        if (ext_gnt | ~ext_req) begin
            waitCnt_d = 8'd0;
        end else if (waitCnt_q < MaxWait) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end else begin
            waitCnt_d = waitCnt_q;
        end

        rvalid_d = ext_gnt & ~ext_we;
        rdata_d  = rvalid_q ? mem_dout : rdata_q;
    end

    // Read data arrives from the BRAM in the rvalid cycle, so pass it straight
    // through then and keep the last returned word afterwards.
    assign ext_rvalid = rvalid_q;
    assign ext_rdata  = rvalid_q ? mem_dout : rdata_q;
    assign cpu_dout   = mem_dout;

    // State registers; reset hands the port back to the CPU and drops any pending read.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= CPU_OWN;
            waitCnt_q <= 8'd0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a
// rule-level reference model of the arbiter and a shadow copy of memory.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        Rst;
    logic        cpu_req, cpu_we;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_addr, cpu_din;
    logic        cpu_stall;
    logic [31:0] cpu_dout;
    logic        ext_req, ext_we, ext_lock;
    logic [3:0]  ext_be;
    logic [31:0] ext_addr, ext_din;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_wea;
    logic [3:0]  mem_en;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .Rst       (Rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_stall (cpu_stall),
        .cpu_dout  (cpu_dout),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_be    (ext_be),
        .ext_addr  (ext_addr),
        .ext_din   (ext_din),
        .ext_lock  (ext_lock),
        .ext_gnt   (ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata (ext_rdata),
        .mem_wea   (mem_wea),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Byte-writable BRAM with one cycle of read latency (read-first).
    logic [31:0] bram [0:15];
    always @(posedge clk) begin
        if (mem_wea) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_en[b]) bram[mem_addr[5:2]][8*b +: 8] <= mem_din[8*b +: 8];
            end
        end
        mem_dout <= bram[mem_addr[5:2]];
    end

    int numChecks = 0;
    int numErrors = 0;

    // Reference model: who owns the port, how long the ext side has waited,
    // and what read data is owed to each side next cycle.
    logic [31:0] shadow [0:15];
    bit          mOwnerExt;
    int          mWaited;
    bit          mPendRead;
    logic [31:0] mPendData, mHeldData;
    bit          mCpuPend;
    logic [31:0] mCpuData;
    bit          mGnt;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mOwnerExt = 1'b0;
        mWaited   = 0;
        mPendRead = 1'b0;
        mPendData = 32'd0;
        mHeldData = 32'd0;
        mCpuPend  = 1'b0;
        mCpuData  = 32'd0;
        mGnt      = 1'b0;
    endtask

    task automatic shadowWrite(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] din);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) shadow[addr[5:2]][8*b +: 8] = din[8*b +: 8];
        end
    endtask

    // Drive one cycle of requests, check every output against the model, then advance it.
    task automatic applyStimulus(
        input logic cReq, input logic cWe, input logic [3:0] cBe,
        input logic [31:0] cAddr, input logic [31:0] cDin,
        input logic eReq, input logic eWe, input logic [3:0] eBe,
        input logic [31:0] eAddr, input logic [31:0] eDin, input logic eLock);
        bit expGnt, expStall, cpuDone, expWea;
        @(posedge clk);
        #1;
        cpu_req = cReq; cpu_we = cWe; cpu_be = cBe; cpu_addr = cAddr; cpu_din = cDin;
        ext_req = eReq; ext_we = eWe; ext_be = eBe; ext_addr = eAddr; ext_din = eDin;
        ext_lock = eLock;
        @(negedge clk);
        expGnt   = eReq && (mOwnerExt || !cReq || mWaited >= MAX_WAIT);
        expStall = mOwnerExt || (cReq && expGnt);
        cpuDone  = cReq && !expStall;
        expWea   = expGnt ? eWe : (cpuDone && cWe);
        checkOutput("ext_gnt", 32'(ext_gnt), 32'(expGnt));
        checkOutput("cpu_stall", 32'(cpu_stall), 32'(expStall));
        checkOutput("mem_wea", 32'(mem_wea), 32'(expWea));
        checkOutput("mem_addr", mem_addr, expGnt ? eAddr : cAddr);
        checkOutput("mem_en", 32'(mem_en), 32'(expGnt ? eBe : cBe));
        checkOutput("mem_din", mem_din, expGnt ? eDin : cDin);
        checkOutput("ext_rvalid", 32'(ext_rvalid), 32'(mPendRead));
        checkOutput("ext_rdata", ext_rdata, mPendRead ? mPendData : mHeldData);
        if (mCpuPend) checkOutput("cpu_dout", cpu_dout, mCpuData);

        if (mPendRead) mHeldData = mPendData;
        mPendRead = expGnt && !eWe;
        if (mPendRead) mPendData = shadow[eAddr[5:2]];
        mCpuPend = cpuDone && !cWe;
        if (mCpuPend) mCpuData = shadow[cAddr[5:2]];
        if (expGnt && eWe) shadowWrite(eAddr, eBe, eDin);
        else if (cpuDone && cWe) shadowWrite(cAddr, cBe, cDin);
        mWaited = (expGnt || !eReq) ? 0 : ((mWaited < MAX_WAIT) ? mWaited + 1 : MAX_WAIT);
        if (expGnt) mOwnerExt = eLock;
        mGnt = expGnt;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Main sequence: reset, preload, directed scenarios, then random traffic.
    initial begin
        int firstGnt;
        int grants;
        int stalls;
        bit done;
        logic        hReq, hWe, hLock;
        logic [3:0]  hBe;
        logic [31:0] hAddr, hDin;

        Rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 4'hF; cpu_addr = 32'h4; cpu_din = 32'h1234;
        ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 32'h8; ext_din = 32'h5678;
        ext_lock = 1'b1;
        modelReset();
        #2;
        checkOutput("reset_gnt", 32'(ext_gnt), 32'd0);
        checkOutput("reset_stall", 32'(cpu_stall), 32'd0);
        checkOutput("reset_wea", 32'(mem_wea), 32'd0);
        checkOutput("reset_rvalid", 32'(ext_rvalid), 32'd0);
        checkOutput("reset_rdata", ext_rdata, 32'd0);
        #10;
        Rst = 1'b1;

        for (int w = 0; w < 16; w++) begin
            applyStimulus(1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        end

        // CPU write then read-back.
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        idleCycle();
        checkOutput("cpu_readback", cpu_dout, 32'hDEADBEEF);

        // External read with the CPU idle: immediate grant, data next cycle.
        applyStimulus(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        checkOutput("idle_ext_gnt", 32'(ext_gnt), 32'd1);
        idleCycle();
        checkOutput("idle_ext_rvalid", 32'(ext_rvalid), 32'd1);
        checkOutput("idle_ext_rdata", ext_rdata, 32'hDEADBEEF);

        // Starvation: the CPU holds the port, ext write forced through after MAX_WAIT.
        firstGnt = -1; grants = 0; stalls = 0; done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, !done, 1'b1, 4'hF, 32'h20, 32'h55, 1'b0);
            if (ext_gnt) begin
                grants++;
                if (firstGnt < 0) firstGnt = i;
                done = 1'b1;
            end
            if (cpu_stall) stalls++;
        end
        checkOutput("starve_first_gnt", 32'(firstGnt), 32'(MAX_WAIT));
        checkOutput("starve_grants", 32'(grants), 32'd1);
        checkOutput("starve_stalls", 32'(stalls), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        idleCycle();
        checkOutput("starve_write_data", cpu_dout, 32'h55);

        // Locked read-modify-write against a busy CPU.
        firstGnt = -1; done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            applyStimulus(1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1);
            if (ext_gnt) begin
                firstGnt = i;
                done = 1'b1;
            end
        end
        checkOutput("lock_first_gnt", 32'(firstGnt), 32'(MAX_WAIT));
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h4, 32'h77, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("lock_idle_stall", 32'(cpu_stall), 32'd1);
        checkOutput("lock_idle_wea", 32'(mem_wea), 32'd0);
        checkOutput("lock_rvalid", 32'(ext_rvalid), 32'd1);
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h4, 32'h77, 1'b1, 1'b1, 4'hF, 32'h30, 32'hA5A5A5A5, 1'b0);
        checkOutput("lock_write_gnt", 32'(ext_gnt), 32'd1);
        checkOutput("lock_write_stall", 32'(cpu_stall), 32'd1);
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("lock_release_stall", 32'(cpu_stall), 32'd0);
        idleCycle();
        checkOutput("lock_rmw_data", cpu_dout, 32'hA5A5A5A5);

        // Idle write suppression.
        applyStimulus(1'b0, 1'b1, 4'hF, 32'h8, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("idle_wea", 32'(mem_wea), 32'd0);

        // Reset in the middle of a locked sequence with a read outstanding.
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        cpu_req = 1'b1; cpu_we = 1'b1; ext_req = 1'b1; ext_we = 1'b0; ext_lock = 1'b1;
        checkOutput("midlock_rvalid", 32'(ext_rvalid), 32'd1);
        checkOutput("midlock_stall", 32'(cpu_stall), 32'd1);
        #1;
        Rst = 1'b0;
        #1;
        checkOutput("midlock_rst_stall", 32'(cpu_stall), 32'd0);
        checkOutput("midlock_rst_gnt", 32'(ext_gnt), 32'd0);
        checkOutput("midlock_rst_rvalid", 32'(ext_rvalid), 32'd0);
        checkOutput("midlock_rst_wea", 32'(mem_wea), 32'd0);
        @(posedge clk);
        @(negedge clk);
        Rst = 1'b1;
        modelReset();
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0);
        checkOutput("post_rst_gnt", 32'(ext_gnt), 32'd0);
        checkOutput("post_rst_stall", 32'(cpu_stall), 32'd0);
        idleCycle();

        // Random traffic; an external request keeps its fields until granted.
        hReq = 1'b0; hWe = 1'b0; hLock = 1'b0; hBe = 4'h0; hAddr = 32'h0; hDin = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!(hReq && !mGnt)) begin
                hReq  = ($urandom_range(0, 3) != 0);
                hWe   = $urandom_range(0, 1) == 1;
                hBe   = 4'($urandom_range(0, 15));
                hAddr = 32'($urandom_range(0, 15)) << 2;
                hDin  = $urandom;
                hLock = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                          4'($urandom_range(0, 15)), 32'($urandom_range(0, 15)) << 2, $urandom,
                          hReq, hWe, hBe, hAddr, hDin, hLock);
        end

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (mem_wea/mem_en/mem_addr/mem_din/mem_dout) between two requesters:
  - the CPU MEM stage;
  - an external master (UART loader/debug DMA).
- The CPU has default priority. The external master uses a req/gnt handshake and is guaranteed forward progress through a starvation counter.
- Supports locked external sequences (e.g. read-modify-write) that hold off the CPU.
- Sits between the Memory stage outputs and the data BRAM. It drives the pipeline stall.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_WAIT, 8, cycles an external request may wait while the CPU holds the port before a forced grant; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access this cycle (memread | memwrite).
- cpu_we  in  1  CPU write.
- cpu_be  in  DATA_W/8  CPU byte enables.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_din  in  DATA_W  CPU store data.
- cpu_stall  out  1  freeze pipeline; CPU access not performed this cycle.
- cpu_dout  out  DATA_W  read data; equals mem_dout.
- ext_req  in  1  external access request; held with its fields until granted.
- ext_we  in  1  external write.
- ext_be  in  DATA_W/8  external byte enables.
- ext_addr  in  ADDR_W  external address.
- ext_din  in  DATA_W  external store data.
- ext_lock  in  1  keep ownership after this access.
- ext_gnt  out  1  external access performed this cycle.
- ext_rvalid  out  1  read data valid (cycle after a granted read).
- ext_rdata  out  DATA_W  external read data.
- mem_wea  out  1  BRAM write enable.
- mem_en  out  DATA_W/8  BRAM byte enables.
- mem_addr  out  ADDR_W  BRAM address.
- mem_din  out  DATA_W  BRAM write data.
- mem_dout  in  DATA_W  BRAM read data; 1-cycle synchronous read latency.

Behaviour:
- Reset (Rst low, asynchronous):
  - state=CPU_OWN, wait_cnt=0, ext_rvalid=0, ext_rdata=0.
  - While Rst is low: ext_gnt=0, cpu_stall=0, mem_wea=0.
- Port mux (combinational): sel_ext = ext_gnt.
  - mem_addr/mem_en/mem_din come from the selected requester.
  - mem_wea = selected_we & selected_req. An idle cycle never writes.
- FSM state CPU_OWN:
  - ext_gnt = ext_req & (!cpu_req | wait_cnt==MAX_WAIT).
  - cpu_stall = cpu_req & ext_gnt.
  - If ext_gnt & ext_lock, next state is EXT_OWN.
- FSM state EXT_OWN:
  - cpu_stall = 1 unconditionally; ext_gnt = ext_req.
  - Return to CPU_OWN after a granted access with ext_lock=0.
  - ext_req=0 in EXT_OWN keeps ownership; the CPU stays stalled.
- wait_cnt (registered, 8-bit internal):
  - Cleared when ext_gnt=1 or ext_req=0.
  - Otherwise increments while ext_req & !ext_gnt, saturating at MAX_WAIT.
- Fairness:
  - After a forced grant, wait_cnt=0, so the next unlocked ext access waits again up to MAX_WAIT cycles.
  - The CPU is therefore stalled at most 1 cycle per MAX_WAIT+1 by unlocked traffic.
- Read return:
  - ext_rvalid is registered as ext_gnt & !ext_we.
  - ext_rdata captures mem_dout when ext_rvalid will be high (sampled the cycle after the grant) and holds otherwise.
- cpu_dout = mem_dout always.
  - The WB stage ignores it on the cycle after a stall because the pipeline did not advance.
- Simultaneous CPU and ext requests with wait_cnt < MAX_WAIT: the CPU wins; ext_gnt=0 and wait_cnt increments.
- Back-to-back external accesses are allowed: a grant is possible every cycle when the CPU is idle or in EXT_OWN.
- Reset asserted mid-lock:
  - Ownership returns to the CPU immediately and pending rvalid is dropped.
  - The external master must re-request.
- MAX_WAIT at saturation with cpu_req=0: a normal (unforced) grant; cpu_stall=0.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_be=4'b1111, cpu_din=0xDEADBEEF → mem_wea=1, mem_addr=0x10, cpu_stall=0, ext_gnt=0. A following CPU read of 0x10 returns 0xDEADBEEF on cpu_dout the next cycle.
- Idle-CPU ext read: cpu_req=0, ext_req=1, ext_we=0, ext_addr=0x10 → ext_gnt=1 the same cycle; ext_rvalid=1 with ext_rdata=0xDEADBEEF the next cycle; cpu_stall=0 throughout.
- Starvation, MAX_WAIT=8: cpu_req held 1, ext_req=1 write 0x55 to 0x20 → ext_gnt=0 for 8 cycles (wait_cnt 0..8). On the 9th cycle ext_gnt=1 and cpu_stall=1 for exactly one cycle; wait_cnt returns to 0.
- Locked RMW: ext read 0x30 with ext_lock=1 while cpu_req=1 (after forced grant) → state EXT_OWN; cpu_stall stays 1. Ext write 0x30 with ext_lock=0 is granted; cpu_stall drops the following cycle.
- Idle write suppression: cpu_req=0, cpu_we=1, ext_req=0 → mem_wea=0.
- Reset mid-lock: assert Rst low in EXT_OWN with ext_rvalid pending → cpu_stall=0, ext_gnt=0, ext_rvalid=0 immediately (asynchronous). After release: state CPU_OWN, wait_cnt=0.
